// File: rtl/line_mem_resp.sv
// line_mem_resp: line-wide memory model with a fixed response latency.
// Optional LINE_MEM_STATS_EN adds rd_cnt/wr_cnt completion counters.
module line_mem_resp #(
   parameter  int LINE_ADDR_LEN = 3,
   parameter  int ADDR_LEN      = 9,
   parameter  int LATENCY       = 8,
   localparam int LINE_SIZE     = 2 ** LINE_ADDR_LEN
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_LEN-1:0] addr,
   input  logic                rd_req,
   input  logic                wr_req,
   input  logic [31:0]         wr_line [LINE_SIZE],
   output logic [31:0]         rd_line [LINE_SIZE],
`ifdef LINE_MEM_STATS_EN
   output logic [31:0]         rd_cnt,
   output logic [31:0]         wr_cnt,
`endif
   output logic                gnt
);

   localparam int DEPTH = 2 ** ADDR_LEN;
   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   typedef logic [LINE_SIZE-1:0][31:0] pline_t;

   // Storage is not touched by reset; it only starts out cleared.
   pline_t mem_q [DEPTH] = '{default: '0};

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                gnt_q, gnt_d;
   logic [ADDR_LEN-1:0] addr_q, addr_d;
   logic                op_wr_q, op_wr_d;
   logic [31:0]         wr_line_q [LINE_SIZE];
   logic [31:0]         wr_line_d [LINE_SIZE];
   logic [31:0]         rd_line_q [LINE_SIZE];
   logic [31:0]         rd_line_d [LINE_SIZE];
   logic                accept;
   logic                fin;
   logic                mem_we;

   // Next-state, request capture and completion of the pending operation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gnt_d     = 1'b0;
      addr_d    = addr_q;
      op_wr_d   = op_wr_q;
      wr_line_d = wr_line_q;
      rd_line_d = rd_line_q;
      accept    = 1'b0;
      fin       = 1'b0;
      mem_we    = 1'b0;
      unique case (state_q)
         IDLE: begin
            accept = rd_req | wr_req;
         end
         BUSY: begin
            if (cnt_q == 8'd0) begin
               fin     = 1'b1;
               gnt_d   = 1'b1;
               state_d = DONE;
               if (op_wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  for (int w = 0; w < LINE_SIZE; w++) begin
                     rd_line_d[w] = mem_q[addr_q][w];
                  end
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         DONE: begin
            // The grant cycle is also the next sampling slot, so a
            // requester holding its level restarts without a bubble.
            state_d = IDLE;
            accept  = rd_req | wr_req;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (accept) begin
         state_d   = BUSY;
         cnt_d     = LAT_M1;
         addr_d    = addr;
         op_wr_d   = wr_req;
         wr_line_d = wr_line;
      end
   end

   // Control and data registers; reset aborts any pending operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         gnt_q     <= 1'b0;
         addr_q    <= '0;
         op_wr_q   <= 1'b0;
         wr_line_q <= '{default: '0};
         rd_line_q <= '{default: '0};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         addr_q    <= addr_d;
         op_wr_q   <= op_wr_d;
         wr_line_q <= wr_line_d;
         rd_line_q <= rd_line_d;
      end
   end

   // Line write on write completion; blocked while reset is asserted.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         for (int w = 0; w < LINE_SIZE; w++) begin
            mem_q[addr_q][w] <= wr_line_q[w];
         end
      end
   end

   assign gnt     = gnt_q;
   assign rd_line = rd_line_q;

`ifdef LINE_MEM_STATS_EN
   logic [31:0] rd_cnt_q, rd_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;

   // Count completed reads and writes, wrapping naturally.
   always_comb begin
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      if (fin) begin
         if (op_wr_q) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
         end else begin
            rd_cnt_d = rd_cnt_q + 32'd1;
         end
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt_q <= 32'd0;
         wr_cnt_q <= 32'd0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign rd_cnt = rd_cnt_q;
   assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_line_mem_resp.sv
// tb_line_mem_resp: directed bench for line_mem_resp (LATENCY=8).
// Build with LINE_MEM_STATS_EN defined to also exercise the counters.
module tb_line_mem_resp;

   logic        clk;
   logic        rst;
   logic [8:0]  addr;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] wr_line [8];
   logic [31:0] rd_line [8];
   logic        gnt;
   logic [255:0] wr_pk;
   logic [255:0] rd_pk;
`ifdef LINE_MEM_STATS_EN
   logic [31:0] rd_cnt;
   logic [31:0] wr_cnt;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   line_mem_resp #(
      .LINE_ADDR_LEN(3),
      .ADDR_LEN(9),
      .LATENCY(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .addr(addr),
      .rd_req(rd_req),
      .wr_req(wr_req),
      .wr_line(wr_line),
      .rd_line(rd_line),
`ifdef LINE_MEM_STATS_EN
      .rd_cnt(rd_cnt),
      .wr_cnt(wr_cnt),
`endif
      .gnt(gnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed views of the line ports.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         wr_line[k] = wr_pk[k*32 +: 32];
         rd_pk[k*32 +: 32] = rd_line[k];
      end
   end

   function automatic logic [255:0] pat(input logic [31:0] base, input bit inc);
      logic [255:0] r;
      for (int k = 0; k < 8; k++) begin
         r[k*32 +: 32] = inc ? base + 32'(k) : base;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold a request until gnt; lat = edges from sampling edge to gnt edge.
   task automatic run_req(input logic rd, input logic wr, input logic [8:0] a,
                          input logic [255:0] d, output int lat);
      int n;
      n = 0;
      lat = -1;
      rd_req = rd;
      wr_req = wr;
      addr = a;
      wr_pk = d;
      while (n < 40) begin
         tick();
         n++;
         if (gnt) begin
            lat = n - 1;
            break;
         end
      end
      rd_req = 1'b0;
      wr_req = 1'b0;
   endtask

   task automatic count_gnt(input int cycles, output int c);
      c = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (gnt) c++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_gnt: got %b want 0", gnt);
      end
      n_cmp++;
      if (rd_pk !== 256'd0) begin
         n_fail++;
         $display("FAIL reset_rd_line: got %h want 0", rd_pk);
      end
   endtask

   task automatic test_read_zero();
      int lat;
      run_req(1'b1, 1'b0, 9'h005, 256'd0, lat);
      n_cmp++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL rd005_lat: got %0d want 8", lat);
      end
      n_cmp++;
      if (rd_pk !== 256'd0) begin
         n_fail++;
         $display("FAIL rd005_data: got %h want 0", rd_pk);
      end
      tick();
      n_cmp++;
      if (gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL rd005_gnt_width: got %b want 0", gnt);
      end
   endtask

   task automatic test_write_read();
      int lat;
      run_req(1'b0, 1'b1, 9'h1A3, pat(32'hA500_0000, 1'b1), lat);
      n_cmp++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL wr1a3_lat: got %0d want 8", lat);
      end
      n_cmp++;
      if (rd_pk !== 256'd0) begin
         n_fail++;
         $display("FAIL wr1a3_rd_line_kept: got %h want 0", rd_pk);
      end
      run_req(1'b1, 1'b0, 9'h1A3, 256'd0, lat);
      n_cmp++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL rd1a3_lat: got %0d want 8", lat);
      end
      n_cmp++;
      if (rd_pk !== pat(32'hA500_0000, 1'b1)) begin
         n_fail++;
         $display("FAIL rd1a3_data: got %h want %h", rd_pk,
                  pat(32'hA500_0000, 1'b1));
      end
   endtask

   task automatic test_both_req();
      int lat;
      int c;
      run_req(1'b1, 1'b1, 9'h010, pat(32'h1234_5678, 1'b0), lat);
      n_cmp++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL both_lat: got %0d want 8", lat);
      end
      n_cmp++;
      if (rd_pk !== pat(32'hA500_0000, 1'b1)) begin
         n_fail++;
         $display("FAIL both_rd_line_kept: got %h want %h", rd_pk,
                  pat(32'hA500_0000, 1'b1));
      end
      count_gnt(12, c);
      n_cmp++;
      if (c !== 0) begin
         n_fail++;
         $display("FAIL both_extra_gnt: got %0d want 0", c);
      end
      run_req(1'b1, 1'b0, 9'h010, 256'd0, lat);
      n_cmp++;
      if (rd_pk !== pat(32'h1234_5678, 1'b0)) begin
         n_fail++;
         $display("FAIL both_readback: got %h want %h", rd_pk,
                  pat(32'h1234_5678, 1'b0));
      end
   endtask

   task automatic test_reset_abort();
      int lat;
      int c;
      rd_req = 1'b0;
      wr_req = 1'b1;
      addr = 9'h020;
      wr_pk = pat(32'hDEAD_BEEF, 1'b0);
      tick();
      wr_req = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #1;
      n_cmp++;
      if (gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_gnt: got %b want 0", gnt);
      end
      n_cmp++;
      if (rd_pk !== 256'd0) begin
         n_fail++;
         $display("FAIL abort_async_rd_line: got %h want 0", rd_pk);
      end
      tick();
      rst = 1'b0;
      count_gnt(12, c);
      n_cmp++;
      if (c !== 0) begin
         n_fail++;
         $display("FAIL abort_gnt_seen: got %0d want 0", c);
      end
      run_req(1'b1, 1'b0, 9'h020, 256'd0, lat);
      n_cmp++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL abort_idle_lat: got %0d want 8", lat);
      end
      n_cmp++;
      if (rd_pk !== 256'd0) begin
         n_fail++;
         $display("FAIL abort_readback: got %h want 0", rd_pk);
      end
   endtask

   task automatic test_busy_change();
      int lat;
      int n;
      rd_req = 1'b0;
      wr_req = 1'b1;
      addr = 9'h033;
      wr_pk = pat(32'h1111_1111, 1'b0);
      tick();
      wr_req = 1'b0;
      addr = 9'h034;
      wr_pk = pat(32'h2222_2222, 1'b0);
      n = 0;
      lat = -1;
      while (n < 40) begin
         tick();
         n++;
         if (gnt) begin
            lat = n;
            break;
         end
      end
      n_cmp++;
      if (lat !== 8) begin
         n_fail++;
         $display("FAIL busy_change_lat: got %0d want 8", lat);
      end
      run_req(1'b1, 1'b0, 9'h033, 256'd0, lat);
      n_cmp++;
      if (rd_pk !== pat(32'h1111_1111, 1'b0)) begin
         n_fail++;
         $display("FAIL busy_change_033: got %h want %h", rd_pk,
                  pat(32'h1111_1111, 1'b0));
      end
      run_req(1'b1, 1'b0, 9'h034, 256'd0, lat);
      n_cmp++;
      if (rd_pk !== 256'd0) begin
         n_fail++;
         $display("FAIL busy_change_034: got %h want 0", rd_pk);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int m;
      run_req(1'b0, 1'b1, 9'h0FF, pat(32'hC0DE_0000, 1'b1), lat);
      tick();
      tick();
      rd_req = 1'b1;
      addr = 9'h1A3;
      m = 0;
      while (m < 40 && !gnt) begin
         tick();
         m++;
      end
      n_cmp++;
      if (rd_pk !== pat(32'hA500_0000, 1'b1)) begin
         n_fail++;
         $display("FAIL b2b_first: got %h want %h", rd_pk,
                  pat(32'hA500_0000, 1'b1));
      end
      addr = 9'h0FF;
      tick();
      n_cmp++;
      if (gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_gnt_width: got %b want 0", gnt);
      end
      m = 1;
      while (m < 40 && !gnt) begin
         tick();
         m++;
      end
      rd_req = 1'b0;
      n_cmp++;
      if (m !== 9) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d want 9", m);
      end
      n_cmp++;
      if (rd_pk !== pat(32'hC0DE_0000, 1'b1)) begin
         n_fail++;
         $display("FAIL b2b_second: got %h want %h", rd_pk,
                  pat(32'hC0DE_0000, 1'b1));
      end
      tick();
      tick();
   endtask

`ifdef LINE_MEM_STATS_EN
   task automatic test_stats();
      int lat;
      do_reset();
      run_req(1'b1, 1'b0, 9'h001, 256'd0, lat);
      run_req(1'b0, 1'b1, 9'h002, pat(32'h5, 1'b1), lat);
      run_req(1'b1, 1'b0, 9'h003, 256'd0, lat);
      run_req(1'b0, 1'b1, 9'h004, pat(32'h9, 1'b0), lat);
      run_req(1'b1, 1'b0, 9'h002, 256'd0, lat);
      tick();
      n_cmp++;
      if (rd_cnt !== 32'd3) begin
         n_fail++;
         $display("FAIL stats_rd: got %0d want 3", rd_cnt);
      end
      n_cmp++;
      if (wr_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL stats_wr: got %0d want 2", wr_cnt);
      end
      do_reset();
      n_cmp++;
      if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0) begin
         n_fail++;
         $display("FAIL stats_reset: got %0d/%0d want 0/0", rd_cnt, wr_cnt);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      rd_req = 1'b0;
      wr_req = 1'b0;
      addr = '0;
      wr_pk = '0;
      test_reset();
      test_read_zero();
      test_write_read();
      test_both_req();
      test_reset_abort();
      test_busy_change();
      test_back_to_back();
`ifdef LINE_MEM_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
